// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register for an opaque ctrl/data bundle under valid/ready, 1-cycle latency.
// SKID=1 adds a second entry so in_ready comes straight from a flop; SKID=0 is a single register.
module pipe_stage_reg #(
  parameter int CTRL_W = 12,
  parameter int DATA_W = 160,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  generate
    if (SKID != 0) begin : g_skid
      typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
      } state_t;

      state_t              state, state_n;
      logic                rdy_q;
      logic                m_v, s_v;
      logic                accept, consume;
      logic                load_m_in, load_m_skid, load_s;
      logic [CTRL_W-1:0]   m_ctrl, s_ctrl;
      logic [DATA_W-1:0]   m_data, s_data;

      assign m_v     = (state != EMPTY);
      assign s_v     = (state == FULL);
      assign accept  = in_valid & rdy_q;
      assign consume = m_v & out_ready;

      always_comb begin
        state_n     = state;
        load_m_in   = 1'b0;
        load_m_skid = 1'b0;
        load_s      = 1'b0;
        case (state)
          EMPTY: begin
            if (accept) begin
              state_n   = BUSY;
              load_m_in = 1'b1;
            end
          end
          BUSY: begin
            if (accept && consume) begin
              load_m_in = 1'b1;
            end else if (accept) begin
              state_n = FULL;
              load_s  = 1'b1;
            end else if (consume) begin
              state_n = EMPTY;
            end
          end
          FULL: begin
            if (consume) begin
              state_n     = BUSY;
              load_m_skid = 1'b1;
            end
          end
          default: state_n = EMPTY;
        endcase
      end

      // rdy_q tracks !s_v one step ahead so in_ready never sees out_ready combinationally
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state <= EMPTY;
          rdy_q <= 1'b1;
        end else if (flush) begin
          state <= EMPTY;
          rdy_q <= 1'b1;
        end else begin
          state <= state_n;
          rdy_q <= (state_n != FULL);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          m_ctrl <= '0;
          m_data <= '0;
          s_ctrl <= '0;
          s_data <= '0;
        end else if (flush) begin
          m_ctrl <= '0;
          m_data <= '0;
          s_ctrl <= '0;
          s_data <= '0;
        end else begin
          if (load_m_in) begin
            m_ctrl <= in_ctrl;
            m_data <= in_data;
          end else if (load_m_skid) begin
            m_ctrl <= s_ctrl;
            m_data <= s_data;
          end
          if (load_s) begin
            s_ctrl <= in_ctrl;
            s_data <= in_data;
          end else if (load_m_skid) begin
            s_ctrl <= '0;
            s_data <= '0;
          end
        end
      end

      assign in_ready  = rdy_q;
      assign out_valid = m_v;
      assign out_ctrl  = m_v ? m_ctrl : '0;
      assign out_data  = m_data;
      assign occ       = {s_v, m_v & ~s_v};
    end else begin : g_single
      logic              m_v;
      logic              accept, consume;
      logic [CTRL_W-1:0] m_ctrl;
      logic [DATA_W-1:0] m_data;

      assign in_ready = ~m_v | out_ready;
      assign accept   = in_valid & in_ready;
      assign consume  = m_v & out_ready;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          m_v    <= 1'b0;
          m_ctrl <= '0;
          m_data <= '0;
        end else if (flush) begin
          m_v    <= 1'b0;
          m_ctrl <= '0;
          m_data <= '0;
        end else if (accept) begin
          m_v    <= 1'b1;
          m_ctrl <= in_ctrl;
          m_data <= in_data;
        end else if (consume) begin
          m_v <= 1'b0;
        end
      end

      assign out_valid = m_v;
      assign out_ctrl  = m_v ? m_ctrl : '0;
      assign out_data  = m_data;
      assign occ       = {1'b0, m_v};
    end
  endgenerate

endmodule
